// File: rtl/progmem_arbiter.sv
// rtl/progmem_arbiter.sv - two-requester arbiter for the shared 64x8 program/data memory
//
// Purpose: grants the CPU core and the debug loader single-cycle access to one
// single-port memory macro. Round-robin on ties, a saturating wait counter per
// requester forces a win after MAX_WAIT denied cycles, and dbg_lock gives the
// debug port exclusive ownership. Read data returns exactly two cycles after
// the accepting cycle on the requester's own rvalid/rdata pair.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU request, held stable until cpu_gnt
//   cpu_gnt                          CPU accepted this cycle (combinational)
//   cpu_rvalid/cpu_rdata             CPU read return (registered)
//   dbg_req/we/addr/wdata            debug request, same rules as CPU
//   dbg_lock                         debug exclusive ownership
//   dbg_gnt, dbg_rvalid/dbg_rdata    as for CPU
//   mem_en/we/addr/wdata             memory strobe and fields of the winner
//   mem_rdata                        memory read data, valid cycle after strobe
module progmem_arbiter #(
   parameter int AW       = 6,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   input  logic          dbg_lock,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int   CW      = $clog2(MAX_WAIT + 1);
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   logic          last_owner;
   logic [CW-1:0] cpu_wait;
   logic [CW-1:0] dbg_wait;
   logic          cpu_elig;
   logic          dbg_elig;
   logic          cpu_sat;
   logic          dbg_sat;
   logic          pick_cpu;
   logic          rd1_vld;
   logic          rd1_dbg;

   always_comb begin
      cpu_elig = cpu_req & ~dbg_lock & ~reset;
      dbg_elig = dbg_req & ~reset;
      cpu_sat  = (cpu_wait == CW'(MAX_WAIT));
      dbg_sat  = (dbg_wait == CW'(MAX_WAIT));
      pick_cpu = 1'b0;
      if (cpu_elig && dbg_elig) begin
         // A single starved requester overrides round-robin; otherwise alternate.
         if (cpu_sat && !dbg_sat)
            pick_cpu = 1'b1;
         else if (dbg_sat && !cpu_sat)
            pick_cpu = 1'b0;
         else
            pick_cpu = (last_owner == OWN_DBG);
      end else begin
         pick_cpu = cpu_elig;
      end
      cpu_gnt = cpu_elig & pick_cpu;
      dbg_gnt = dbg_elig & ~pick_cpu;
      mem_en  = cpu_gnt | dbg_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dbg_gnt) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner <= OWN_DBG;
         cpu_wait   <= '0;
         dbg_wait   <= '0;
         rd1_vld    <= 1'b0;
         rd1_dbg    <= 1'b0;
         cpu_rvalid <= 1'b0;
         dbg_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         dbg_rdata  <= '0;
      end else begin
         if (mem_en)
            last_owner <= dbg_gnt ? OWN_DBG : OWN_CPU;

         // The CPU counter holds its value while the debug lock is active.
         if (!dbg_lock) begin
            if (cpu_req && !cpu_gnt) begin
               if (!cpu_sat)
                  cpu_wait <= cpu_wait + CW'(1);
            end else begin
               cpu_wait <= '0;
            end
         end
         if (dbg_req && !dbg_gnt) begin
            if (!dbg_sat)
               dbg_wait <= dbg_wait + CW'(1);
         end else begin
            dbg_wait <= '0;
         end

         // Stage 1 marks the read strobe; stage 2 captures mem_rdata and pulses rvalid.
         rd1_vld    <= mem_en & ~mem_we;
         rd1_dbg    <= dbg_gnt;
         cpu_rvalid <= rd1_vld & ~rd1_dbg;
         dbg_rvalid <= rd1_vld & rd1_dbg;
         if (rd1_vld && !rd1_dbg)
            cpu_rdata <= mem_rdata;
         if (rd1_vld && rd1_dbg)
            dbg_rdata <= mem_rdata;
      end
   end

endmodule
